// File: rtl/div_radix2.sv
// 32-bit radix-2 restoring divider for the EX stage: DIV/DIVU with annul support.
// Returns {remainder, quotient} one cycle-registered, held until start_i drops.
module div_radix2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic [1:0]  dbg_state
);

    // Handshake: requester holds start_i high until it samples ready_o=1, then
    // drops start_i; ready_o/result_o are registered and valid only together.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [5:0]  cnt;
    logic [31:0] rem, quo, dsr;
    logic        sgn, neg_a, neg_b;

    logic [31:0] abs_a, abs_b;
    logic [33:0] trial;
    logic [31:0] quo_fix, rem_fix;

    assign abs_a = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
    assign abs_b = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;

    // Shifted partial remainder can reach 33 bits; bit 33 of the difference is the borrow.
    assign trial   = {1'b0, rem, quo[31]} - {2'b00, dsr};
    assign quo_fix = (sgn && (neg_a ^ neg_b)) ? (32'd0 - quo) : quo;
    assign rem_fix = (sgn && neg_a) ? (32'd0 - rem) : rem;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_i && !annul_i)
                    state_next = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
            end
            S_BYZERO: state_next = annul_i ? S_IDLE : S_END;
            S_ON: begin
                if (annul_i)            state_next = S_IDLE;
                else if (cnt == 6'd32)  state_next = S_END;
            end
            S_END: begin
                if (!start_i) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 6'd0;
            rem      <= 32'd0;
            quo      <= 32'd0;
            dsr      <= 32'd0;
            sgn      <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i && !annul_i && opdata2_i != 32'd0) begin
                        quo   <= abs_a;
                        dsr   <= abs_b;
                        rem   <= 32'd0;
                        cnt   <= 6'd0;
                        sgn   <= signed_div_i;
                        neg_a <= signed_div_i & opdata1_i[31];
                        neg_b <= signed_div_i & opdata2_i[31];
                    end
                end
                S_BYZERO: begin
                    if (!annul_i) begin
                        result_o <= 64'd0;
                        ready_o  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (!annul_i) begin
                        if (cnt == 6'd32) begin
                            result_o <= {rem_fix, quo_fix};
                            ready_o  <= 1'b1;
                        end else begin
                            if (!trial[33]) begin
                                rem <= trial[31:0];
                                quo <= {quo[30:0], 1'b1};
                            end else begin
                                rem <= {rem[30:0], quo[31]};
                                quo <= {quo[30:0], 1'b0};
                            end
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
